fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Holds the PC and issues one word request at a time to instruction memory over a valid/ready request channel with a valid-only response.
- Presents a registered instruction word plus its PC to decode, and honours decode stall and execute redirect.
- Non-pipelined: at most one outstanding memory request.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
//   imem_req_valid  : fetch -> mem, request valid
//   imem_req_ready  : mem -> fetch, request accepted this cycle
//   imem_req_addr   : fetch -> mem, word-aligned request address
//   imem_resp_valid : mem -> fetch, one response per accepted request
//   imem_resp_data  : mem -> fetch, fetched instruction word
// master = fetch side, slave = memory side.
interface fetch_unit_if #(
    parameter int ADDRESS_SIZE = 32
);
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [ADDRESS_SIZE-1:0] imem_req_addr;
    logic                    imem_resp_valid;
    logic [ADDRESS_SIZE-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decoder.
// Holds the PC, issues one word request at a time over imem (valid/ready
// request, valid-only response), and presents a registered instruction
// plus its PC to decode. Honours decode stall and execute redirect.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem            : instruction memory bus (master side)
//   stall           : decode cannot take the instruction this cycle
//   redirect_valid  : load redirect_pc, discard anything in flight
//   redirect_pc     : redirect target (low two bits ignored)
//   instr_valid     : instruction / instr_pc are valid
//   instruction     : instruction word to decode (NOP_INSTR when idle)
//   instr_pc        : PC of the instruction
module fetch_unit #(
    parameter int                         ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0]    RESET_PC     = '0,
    parameter logic [ADDRESS_SIZE-1:0]    NOP_INSTR    = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fetch_unit_if.master            imem,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    instr_valid,
    output logic [ADDRESS_SIZE-1:0] instruction,
    output logic [ADDRESS_SIZE-1:0] instr_pc
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] hold_data;
    logic [ADDRESS_SIZE-1:0] hold_pc;
    logic                    slot_free;

    localparam logic [ADDRESS_SIZE-1:0] PC_STEP  = ADDRESS_SIZE'(4);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(3);

    // Request valid is gated by rst_n so it drops immediately on reset.
    assign imem.imem_req_valid = (state == REQ) && rst_n;
    assign imem.imem_req_addr  = pc;

    // The output register can take a new word if it is empty or being consumed.
    assign slot_free = !instr_valid || !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            hold_data   <= '0;
            hold_pc     <= '0;
        end else begin
            // Consumption; a load below in the same cycle overrides this.
            if (instr_valid && !stall) begin
                instr_valid <= 1'b0;
                instruction <= NOP_INSTR;
            end

            if (redirect_valid) begin
                pc          <= redirect_pc & ALIGN_MASK;
                instr_valid <= 1'b0;
                instruction <= NOP_INSTR;
                hold_data   <= '0;
                hold_pc     <= '0;
                unique case (state)
                    // An accepted old request still owes a response.
                    REQ:  state <= imem.imem_req_ready ? DROP : REQ;
                    WAIT: state <= imem.imem_resp_valid ? REQ : DROP;
                    HOLD: state <= REQ;
                    DROP: state <= DROP;
                    default: state <= REQ;
                endcase
            end else begin
                unique case (state)
                    REQ: begin
                        if (imem.imem_req_ready) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem.imem_resp_valid) begin
                            pc <= pc + PC_STEP;
                            if (slot_free) begin
                                instruction <= imem.imem_resp_data;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                                state       <= REQ;
                            end else begin
                                hold_data <= imem.imem_resp_data;
                                hold_pc   <= pc;
                                state     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        // instr_valid is always set here, so the slot frees on !stall.
                        if (!stall) begin
                            instruction <= hold_data;
                            instr_pc    <= hold_pc;
                            instr_valid <= 1'b1;
                            state       <= REQ;
                        end
                    end
                    DROP: begin
                        if (imem.imem_resp_valid) begin
                            state <= REQ;
                        end
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    logic        mem_ready = 1'b1;
    int unsigned resp_delay = 0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDRESS_SIZE(32)) bus_a ();

    fetch_unit #(
        .ADDRESS_SIZE(32),
        .RESET_PC(32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem(bus_a),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_pc(instr_pc)
    );

    // Memory model A: word at address a is a + 0xA0, optional extra delay.
    logic        pend;
    int unsigned cnt;
    logic [31:0] paddr;
    int unsigned acc4;

    assign bus_a.imem_req_ready  = mem_ready;
    assign bus_a.imem_resp_valid = pend && (cnt == 0);
    assign bus_a.imem_resp_data  = paddr + 32'h0000_00A0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= '0;
            acc4  <= 0;
        end else begin
            if (bus_a.imem_req_valid && bus_a.imem_req_ready && bus_a.imem_req_addr == 32'h4)
                acc4 <= acc4 + 1;
            if (!pend) begin
                if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
                    pend  <= 1'b1;
                    cnt   <= resp_delay;
                    paddr <= bus_a.imem_req_addr;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
            end else begin
                pend <= 1'b0;
            end
        end
    end

    // Second instance starting at the top of the address space, zero-wait memory.
    logic        stall_b = 1'b0;
    logic        redirect_b = 1'b0;
    logic [31:0] redirect_pc_b = '0;
    logic        instr_valid_b;
    logic [31:0] instruction_b;
    logic [31:0] instr_pc_b;
    logic        pend_b;
    logic [31:0] data_b;

    fetch_unit_if #(.ADDRESS_SIZE(32)) bus_b ();

    fetch_unit #(
        .ADDRESS_SIZE(32),
        .RESET_PC(32'hFFFF_FFFC),
        .NOP_INSTR(32'h0000_0013)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .imem(bus_b),
        .stall(stall_b),
        .redirect_valid(redirect_b),
        .redirect_pc(redirect_pc_b),
        .instr_valid(instr_valid_b),
        .instruction(instruction_b),
        .instr_pc(instr_pc_b)
    );

    assign bus_b.imem_req_ready  = 1'b1;
    assign bus_b.imem_resp_valid = pend_b;
    assign bus_b.imem_resp_data  = data_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_b <= 1'b0;
            data_b <= '0;
        end else begin
            pend_b <= bus_b.imem_req_valid;
            data_b <= bus_b.imem_req_addr + 32'h0000_00A0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset with default stimulus, check reset state, release on a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ready = 1'b1;
        resp_delay = 0;
        repeat (2) tick();
        check("rst_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", instruction, 32'h13);
        check("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Test 1: zero-wait streaming, plus the wrap-around instance.
        do_reset();
        check("t1_n0_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("t1_n0_req_addr", bus_a.imem_req_addr, 32'h0);
        check("t1_b_n0_addr", bus_b.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("t1_n1_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("t1_n1_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t1_n2_instr_valid", 32'(instr_valid), 32'd1);
        check("t1_n2_instruction", instruction, 32'hA0);
        check("t1_n2_pc", instr_pc, 32'h0);
        check("t1_n2_req_addr", bus_a.imem_req_addr, 32'h4);
        check("t1_b_n2_instr_pc", instr_pc_b, 32'hFFFF_FFFC);
        check("t1_b_n2_instruction", instruction_b, 32'h9C);
        check("t1_b_n2_req_addr", bus_b.imem_req_addr, 32'h0);
        tick();
        check("t1_n3_instr_valid", 32'(instr_valid), 32'd0);
        check("t1_n3_instruction", instruction, 32'h13);
        tick();
        check("t1_n4_instruction", instruction, 32'hA4);
        check("t1_n4_pc", instr_pc, 32'h4);
        check("t1_n4_req_addr", bus_a.imem_req_addr, 32'h8);
        repeat (2) tick();
        check("t1_n6_instr_valid", 32'(instr_valid), 32'd1);
        check("t1_n6_instruction", instruction, 32'hA8);
        check("t1_n6_pc", instr_pc, 32'h8);

        // Test 2: ready held low for three cycles on address 4.
        do_reset();
        tick();
        mem_ready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t2_held_valid", 32'(bus_a.imem_req_valid), 32'd1);
            check("t2_held_addr", bus_a.imem_req_addr, 32'h4);
        end
        tick();
        check("t2_n5_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("t2_n5_addr", bus_a.imem_req_addr, 32'h4);
        check("t2_n5_acc4", acc4, 32'd0);
        mem_ready = 1'b1;
        tick();
        check("t2_n6_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        tick();
        check("t2_n7_instruction", instruction, 32'hA4);
        check("t2_n7_pc", instr_pc, 32'h4);
        check("t2_n7_acc4", acc4, 32'd1);

        // Test 3: stall while the next response arrives.
        do_reset();
        repeat (2) tick();
        check("t3_n2_instruction", instruction, 32'hA0);
        stall = 1'b1;
        for (int i = 3; i <= 7; i++) begin
            tick();
            check("t3_frozen_valid", 32'(instr_valid), 32'd1);
            check("t3_frozen_instr", instruction, 32'hA0);
            check("t3_frozen_pc", instr_pc, 32'h0);
            check("t3_no_req", 32'(bus_a.imem_req_valid), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("t3_n8_instr_valid", 32'(instr_valid), 32'd1);
        check("t3_n8_instruction", instruction, 32'hA4);
        check("t3_n8_pc", instr_pc, 32'h4);
        check("t3_n8_req_addr", bus_a.imem_req_addr, 32'h8);

        // Test 4: redirect while waiting on address 8.
        do_reset();
        repeat (4) tick();
        check("t4_n4_req_addr", bus_a.imem_req_addr, 32'h8);
        resp_delay = 2;
        tick();
        check("t4_n5_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("t4_n6_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("t4_n6_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t4_n7_instr_valid", 32'(instr_valid), 32'd0);
        check("t4_n7_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        tick();
        check("t4_n8_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("t4_n8_req_addr", bus_a.imem_req_addr, 32'h100);
        check("t4_n8_instr_valid", 32'(instr_valid), 32'd0);
        resp_delay = 0;
        tick();
        check("t4_n9_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t4_n10_instr_valid", 32'(instr_valid), 32'd1);
        check("t4_n10_instruction", instruction, 32'h1A0);
        check("t4_n10_pc", instr_pc, 32'h100);

        // Test 6: reset asserted while holding under stall.
        do_reset();
        repeat (2) tick();
        stall = 1'b1;
        repeat (2) tick();
        check("t6_hold_instr_valid", 32'(instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_instr_valid", 32'(instr_valid), 32'd0);
        check("t6_async_instruction", instruction, 32'h13);
        check("t6_async_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        tick();
        stall = 1'b0;
        rst_n = 1'b1;
        #1;
        check("t6_rel_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("t6_rel_req_addr", bus_a.imem_req_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
